// File: rtl/ahb_req_queue.sv
// Command FIFO in front of an AHB master's user port: issues queued beats, inserts
// BUSY cycles when an open burst runs dry, drains the rest of a burst after an error.
module ahb_req_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_write,
  input  logic [2:0]            cmd_size,
  input  logic [2:0]            cmd_burst,
  input  logic                  cmd_last,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  m_sel,
  output logic                  m_valid,
  output logic                  m_busy,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic                  m_write,
  output logic [2:0]            m_size,
  output logic [2:0]            m_burst,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic                  m_ready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic                  m_master_error,
  input  logic                  m_other_error,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_write,
  output logic                  rsp_error
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DRAIN = 2'd2} state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  write;
    logic [2:0]            size;
    logic [2:0]            burst;
    logic                  last;
    logic [DATA_WIDTH-1:0] wdata;
  } cmd_t;

  cmd_t                  mem_q [DEPTH];
  cmd_t                  head;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]           count_q, count_d;
  state_e                state_q, state_d;
  logic [4:0]            cnt_q, cnt_d;
  logic                  incr_q, incr_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_write_q, rsp_write_d;
  logic                  rsp_error_q, rsp_error_d;

  logic empty, ok, push, pop, hs, drain_pop, beat_err;
  logic head_incr, first_final, beat_final;

  function automatic logic [4:0] burst_len_m1(input logic [2:0] burst);
    case (burst[2:1])
      2'b01:   return 5'd3;
      2'b10:   return 5'd7;
      2'b11:   return 5'd15;
      default: return 5'd0;
    endcase
  endfunction

  assign empty     = (count_q == '0);
  assign cmd_ready = !rst && !count_q[PW];
  assign push      = cmd_valid && cmd_ready;
  assign head      = empty ? '0 : mem_q[rd_ptr_q];
  assign ok        = !empty && (!rsp_valid_q || rsp_ready);
  assign hs        = m_valid && m_ready;
  assign pop       = hs || drain_pop;
  assign beat_err  = m_master_error || m_other_error;

  assign head_incr   = (head.burst == 3'b001);
  assign first_final = (head.burst == 3'b000) || (head_incr && head.last);
  assign beat_final  = incr_q ? head.last : (cnt_q == 5'd1);

  assign m_addr    = head.addr;
  assign m_write   = head.write;
  assign m_size    = head.size;
  assign m_burst   = head.burst;
  assign m_wdata   = head.wdata;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_write = rsp_write_q;
  assign rsp_error = rsp_error_q;

  // Request strobes stay combinational so a rising rsp_ready resumes issue in the same cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    m_sel   = 1'b0;
    m_valid = 1'b0;
    m_busy  = 1'b0;
    case (state_q)
      IDLE: begin
        m_sel   = ok;
        m_valid = ok;
      end
      ACTIVE: begin
        m_sel   = 1'b1;
        m_valid = ok;
        m_busy  = !ok;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    incr_d    = incr_q;
    drain_pop = 1'b0;
    case (state_q)
      IDLE: if (hs) begin
        incr_d = head_incr;
        cnt_d  = burst_len_m1(head.burst);
        if (!first_final) state_d = beat_err ? DRAIN : ACTIVE;
      end
      ACTIVE: if (hs) begin
        if (!incr_q) cnt_d = cnt_q - 5'd1;
        if (beat_final)    state_d = IDLE;
        else if (beat_err) state_d = DRAIN;
      end
      DRAIN: if (ok) begin
        drain_pop = 1'b1;
        if (!incr_q) cnt_d = cnt_q - 5'd1;
        if (beat_final) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + (PW+1)'(1);
    else if (!push && pop) count_d = count_q - (PW+1)'(1);
  end

  // Drained beats report an error with zero data; a completed read returns m_rdata.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_write_d = rsp_write_q;
    rsp_error_d = rsp_error_q;
    if (pop) begin
      rsp_valid_d = 1'b1;
      rsp_write_d = head.write;
      rsp_rdata_d = (drain_pop || head.write) ? '0 : m_rdata;
      rsp_error_d = drain_pop || beat_err;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // NOTE: the payload array has no reset; count_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{addr: cmd_addr, write: cmd_write, size: cmd_size,
                           burst: cmd_burst, last: cmd_last, wdata: cmd_wdata};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      incr_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_write_q <= 1'b0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      incr_q      <= incr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_write_q <= rsp_write_d;
      rsp_error_q <= rsp_error_d;
    end
  end

endmodule

// File: tb/tb_ahb_req_queue.sv
// Directed bench for ahb_req_queue: stimulus queues expected responses, a monitor
// pops and compares them whenever a response handshake is presented.
module tb_ahb_req_queue;

  localparam int EXP_OK    = 0;  // normal completion
  localparam int EXP_ERR   = 1;  // completed with error, data kept
  localparam int EXP_DRAIN = 2;  // flushed, error with zero data
  localparam int EXP_NONE  = 3;  // no response expected

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_last;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [2:0]  cmd_size, cmd_burst;
  logic        m_sel, m_valid, m_busy, m_write, m_ready;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [2:0]  m_size, m_burst;
  logic        m_master_error, m_other_error;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_error;
  logic [31:0] rsp_rdata;

  logic        err_arm = 1'b0, err_master = 1'b0;
  logic [31:0] err_addr = '0;

  typedef struct {
    logic        write;
    logic [31:0] rdata;
    logic        error;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_checks = 0, n_errors = 0, hs_count = 0;

  always #5 clk = ~clk;

  // Slave model: read data is derived from the address; errors hit one armed address.
  assign m_rdata        = (m_addr >> 2) + 32'd1;
  assign m_other_error  = err_arm && !err_master && (m_addr == err_addr);
  assign m_master_error = err_arm &&  err_master && (m_addr == err_addr);

  ahb_req_queue #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .cmd_last(cmd_last), .cmd_wdata(cmd_wdata),
    .m_sel(m_sel), .m_valid(m_valid), .m_busy(m_busy), .m_addr(m_addr),
    .m_write(m_write), .m_size(m_size), .m_burst(m_burst), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata),
    .m_master_error(m_master_error), .m_other_error(m_other_error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_write(rsp_write), .rsp_error(rsp_error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge; presents one command for one cycle and queues its expected response.
  task automatic push(input logic [31:0] a, input logic w, input logic [2:0] b,
                      input logic l, input logic [31:0] d, input int kind);
    rsp_t e;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_write = w;
    cmd_size  = 3'b010;
    cmd_burst = b;
    cmd_last  = l;
    cmd_wdata = d;
    #1;
    check("push_cmd_ready", 32'(cmd_ready), 32'd1);
    if (kind != EXP_NONE) begin
      e.write = w;
      e.rdata = (w || kind == EXP_DRAIN) ? 32'd0 : (a >> 2) + 32'd1;
      e.error = (kind != EXP_OK);
      exp_q.push_back(e);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Monitor: samples mid-cycle, where inputs and outputs are stable until the next rising edge.
  always @(negedge clk) begin : monitor
    rsp_t e;
    #2;
    if (m_valid && m_ready && !rst) hs_count++;
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rsp_unexpected: got rdata=0x%0h err=%0b expected no response", rsp_rdata, rsp_error);
      end else begin
        e = exp_q.pop_front();
        check("rsp_write", 32'(rsp_write), 32'(e.write));
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_error", 32'(rsp_error), 32'(e.error));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int hs0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0; cmd_size = '0;
    cmd_burst = '0; cmd_last = 1'b0; cmd_wdata = '0; m_ready = 1'b1; rsp_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_m_valid",   32'(m_valid),   32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("post_rst_m_sel",     32'(m_sel),     32'd0);
    check("post_rst_m_addr",    m_addr,         32'd0);
    @(negedge clk);

    // Single write
    push(32'h100, 1'b1, 3'b000, 1'b0, 32'hA5A5A5A5, EXP_OK);
    #1;
    check("t1_m_valid", 32'(m_valid), 32'd1);
    check("t1_m_addr",  m_addr,       32'h100);
    check("t1_m_wdata", m_wdata,      32'hA5A5A5A5);
    check("t1_m_write", 32'(m_write), 32'd1);
    check("t1_m_size",  32'(m_size),  32'd2);
    @(negedge clk); #1;
    check("t1_rsp_valid",   32'(rsp_valid), 32'd1);
    check("t1_m_valid_off", 32'(m_valid),   32'd0);
    repeat (2) @(negedge clk);

    // INCR4 read, FIFO fill
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(32'(4 * i), 1'b0, 3'b011, 1'b0, 32'd0, EXP_OK);
    #1;
    check("t2_full_cmd_ready", 32'(cmd_ready), 32'd0);
    check("t2_m_burst",        32'(m_burst),   32'd3);
    m_ready = 1'b1;
    #1;
    check("t2_pop_no_ready", 32'(cmd_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("t2_m_sel",     32'(m_sel),     32'd1);
      check("t2_m_valid",   32'(m_valid),   32'd1);
      check("t2_m_addr",    m_addr,         32'(4 * i));
      check("t2_rsp_valid", 32'(rsp_valid), (i > 0) ? 32'd1 : 32'd0);
      @(negedge clk); #1;
    end
    check("t2_m_sel_end",   32'(m_sel),     32'd0);
    check("t2_m_valid_end", 32'(m_valid),   32'd0);
    check("t2_rsp_last",    32'(rsp_valid), 32'd1);
    repeat (2) @(negedge clk);

    // BUSY insertion
    push(32'h200, 1'b0, 3'b011, 1'b0, 32'd0, EXP_OK);
    push(32'h204, 1'b0, 3'b011, 1'b0, 32'd0, EXP_OK);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t3_m_busy",  32'(m_busy),  32'd1);
      check("t3_m_sel",   32'(m_sel),   32'd1);
      check("t3_m_valid", 32'(m_valid), 32'd0);
      @(negedge clk);
    end
    push(32'h208, 1'b0, 3'b011, 1'b0, 32'd0, EXP_OK);
    push(32'h20C, 1'b0, 3'b011, 1'b0, 32'd0, EXP_OK);
    #1;
    check("t3_beat4_valid", 32'(m_valid), 32'd1);
    check("t3_beat4_busy",  32'(m_busy),  32'd0);
    @(negedge clk); #1;
    check("t3_end_sel",  32'(m_sel),  32'd0);
    check("t3_end_busy", 32'(m_busy), 32'd0);
    repeat (2) @(negedge clk);

    // Error drain on INCR8 beat 3, then SINGLE beats in IDLE
    hs0 = hs_count;
    err_arm = 1'b1; err_master = 1'b0; err_addr = 32'h308;
    for (int i = 0; i < 8; i++)
      push(32'h300 + 32'(4 * i), 1'b0, 3'b101, 1'b0, 32'd0,
           (i < 2) ? EXP_OK : (i == 2) ? EXP_ERR : EXP_DRAIN);
    #1;
    check("t4_drain_valid", 32'(m_valid), 32'd0);
    check("t4_drain_sel",   32'(m_sel),   32'd0);
    check("t4_drain_busy",  32'(m_busy),  32'd0);
    @(negedge clk);
    push(32'h400, 1'b0, 3'b000, 1'b0, 32'd0, EXP_OK);
    #1;
    check("t4_single_valid", 32'(m_valid), 32'd1);
    check("t4_single_addr",  m_addr,       32'h400);
    @(negedge clk);
    check("t4_handshakes", 32'(hs_count - hs0), 32'd4);
    err_master = 1'b1; err_addr = 32'h500;
    push(32'h500, 1'b1, 3'b000, 1'b0, 32'h55, EXP_ERR);
    #1;
    check("t4_err_single_valid", 32'(m_valid), 32'd1);
    push(32'h504, 1'b0, 3'b000, 1'b0, 32'd0, EXP_OK);
    #1;
    check("t4_after_err_valid", 32'(m_valid), 32'd1);
    check("t4_after_err_addr",  m_addr,       32'h504);
    @(negedge clk);
    err_arm = 1'b0;
    repeat (2) @(negedge clk);

    // Response backpressure
    rsp_ready = 1'b0; m_ready = 1'b0;
    push(32'h600, 1'b0, 3'b011, 1'b0, 32'd0, EXP_OK);
    push(32'h604, 1'b0, 3'b011, 1'b0, 32'd0, EXP_OK);
    push(32'h608, 1'b0, 3'b011, 1'b0, 32'd0, EXP_OK);
    m_ready = 1'b1;
    #1;
    check("t5_first_valid", 32'(m_valid), 32'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      check("t5_bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("t5_bp_rsp_rdata", rsp_rdata,      32'h181);
      check("t5_bp_m_valid",   32'(m_valid),   32'd0);
      check("t5_bp_m_busy",    32'(m_busy),    32'd1);
      check("t5_bp_m_sel",     32'(m_sel),     32'd1);
    end
    rsp_ready = 1'b1;
    #1;
    check("t5_resume_valid", 32'(m_valid), 32'd1);
    check("t5_resume_busy",  32'(m_busy),  32'd0);
    repeat (2) @(negedge clk);
    #1;
    check("t5_dry_busy", 32'(m_busy), 32'd1);
    push(32'h60C, 1'b0, 3'b011, 1'b0, 32'd0, EXP_OK);
    @(negedge clk); #1;
    check("t5_end_sel", 32'(m_sel), 32'd0);
    repeat (2) @(negedge clk);

    // Reset mid-burst (INCR16 beat 2 on the bus)
    push(32'h700, 1'b0, 3'b111, 1'b0, 32'd0, EXP_OK);
    push(32'h704, 1'b0, 3'b111, 1'b0, 32'd0, EXP_NONE);
    rst = 1'b1;
    cmd_valid = 1'b1; cmd_addr = 32'h708; cmd_burst = 3'b111; cmd_write = 1'b0;
    @(negedge clk); #1;
    check("t6_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("t6_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    cmd_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    check("t6_cmd_ready", 32'(cmd_ready), 32'd1);
    check("t6_m_sel",     32'(m_sel),     32'd0);
    check("t6_m_valid",   32'(m_valid),   32'd0);
    check("t6_m_busy",    32'(m_busy),    32'd0);
    check("t6_m_addr",    m_addr,         32'd0);
    check("t6_m_fields",  32'({m_write, m_size, m_burst}), 32'd0);
    check("t6_m_wdata",   m_wdata,        32'd0);
    check("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t6_rsp_rdata", rsp_rdata,      32'd0);
    check("t6_rsp_flags", 32'({rsp_write, rsp_error}), 32'd0);
    @(negedge clk);
    push(32'h800, 1'b0, 3'b000, 1'b0, 32'd0, EXP_OK);
    #1;
    check("t6_fresh_valid", 32'(m_valid), 32'd1);
    check("t6_fresh_addr",  m_addr,       32'h800);
    @(negedge clk);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
